// File: rtl/muldiv_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_ctrl_pkg
// Brief    : Shared encodings and constants for the mul/div sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_seq_ctrl_pkg;

    // Operation encodings as presented on the op bus
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } md_state_e;

    // Divide latency: 1 load + 32 iterations + 1 sign fix
    localparam int DIV_LAT   = 34;
    localparam int DIV_STEPS = 32;

    // Wide enough for the longest count (DIV_LAT-2 = 32)
    localparam int CNT_W = 6;

    // Absolute value when the operand is treated as signed, raw value otherwise
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_ctrl_if
// Brief    : EXE-stage handshake bundle between the pipeline and the
//            mul/div sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_seq_ctrl_if;
    import muldiv_seq_ctrl_pkg::*;

    logic        req;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        hold;
    logic        stall_req;
    logic        result_valid;
    logic [63:0] result;
    logic        busy;

    // Pipeline side
    modport master (
        output req, op, src_a, src_b, flush, hold,
        input  stall_req, result_valid, result, busy
    );

    // Sequencer side
    modport slave (
        input  req, op, src_a, src_b, flush, hold,
        output stall_req, result_valid, result, busy
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_seq_ctrl_div_iter_r2.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_r2
// Brief    : Restoring radix-2 unsigned divider, one quotient bit per cycle.
//            Loads on start, runs 32 iterations, then holds done until the
//            next start or abort. Magnitudes in, magnitudes out.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter_r2
    import muldiv_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic [31:0]      rem;
    logic [31:0]      quo;
    logic [31:0]      dsr;
    logic [CNT_W-1:0] step;
    logic             running;
    logic             done_reg;
    logic [32:0]      shifted;
    logic [32:0]      diff;

    // Trial subtraction: partial remainder shifted left with the next dividend bit
    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dsr};
    end

    // Iteration registers: quotient bits shift in where the dividend bits shift out
    always_ff @(posedge clk) begin
        if (rst) begin
            rem      <= '0;
            quo      <= '0;
            dsr      <= '0;
            step     <= '0;
            running  <= 1'b0;
            done_reg <= 1'b0;
        end else if (abort) begin
            running  <= 1'b0;
            done_reg <= 1'b0;
        end else if (start) begin
            rem      <= '0;
            quo      <= dividend;
            dsr      <= divisor;
            step     <= '0;
            running  <= 1'b1;
            done_reg <= 1'b0;
        end else if (running) begin
            // A borrow out of bit 32 means the divisor did not fit: restore
            quo  <= {quo[30:0], ~diff[32]};
            rem  <= diff[32] ? shifted[31:0] : diff[31:0];
            step <= step + CNT_W'(1);
            if (step == CNT_W'(DIV_STEPS - 1)) begin
                running  <= 1'b0;
                done_reg <= 1'b1;
            end
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
    assign done      = done_reg;

endmodule
`default_nettype wire

// File: rtl/muldiv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_ctrl
// Brief    : EXE-stage sequencer for the shared multiply/divide unit. Holds
//            the stall request until the {HI,LO} result is ready, aborts on
//            flush, and keeps the result stable while the pipeline is held.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq_ctrl
    import muldiv_seq_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    muldiv_seq_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] MUL_END = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_END = CNT_W'(DIV_LAT - 2);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             busy_reg;
    logic             valid_reg;
    logic [63:0]      result_reg;

    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_signed;
    logic             neg_quo;
    logic             neg_rem;

    logic             accept;
    logic             stall;
    logic [63:0]      ext_a;
    logic [63:0]      ext_b;
    logic [63:0]      mul_prod;
    logic [63:0]      mul_out;

    logic             div_start;
    logic [31:0]      div_a;
    logic [31:0]      div_b;
    logic [31:0]      div_quo;
    logic [31:0]      div_rem;
    logic             div_done;
    logic [31:0]      quo_fix;
    logic [31:0]      rem_fix;

    // Accept and stall decode; flush and reset suppress both in the same cycle
    always_comb begin
        accept = 1'b0;
        stall  = 1'b0;
        if (!rst && !bus.flush) begin
            accept = (state == S_IDLE) && bus.req;
            stall  = accept || (state == S_MUL) || (state == S_DIV);
        end
    end

    // Product of the latched operands; low 64 bits are exact for both signednesses
    always_comb begin
        ext_a    = {{32{mul_signed & mul_a[31]}}, mul_a};
        ext_b    = {{32{mul_signed & mul_b[31]}}, mul_b};
        mul_prod = ext_a * ext_b;
    end

    // Product stages: MUL_LAT-2 pipeline registers plus the result register
    generate
        if (MUL_LAT == 2) begin : g_mul_direct
            assign mul_out = mul_prod;
        end else begin : g_mul_pipe
            logic [63:0] pipe [MUL_LAT-2];

            // Shift the product down the pipeline every cycle
            always_ff @(posedge clk) begin
                pipe[0] <= mul_prod;
                for (int i = 1; i < MUL_LAT - 2; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end

            assign mul_out = pipe[MUL_LAT-3];
        end
    endgenerate

    // The divider loads straight from the forwarded operands in the accept cycle
    assign div_start = accept && bus.op[1];
    assign div_a     = mag32(bus.src_a, bus.op == MD_DIV);
    assign div_b     = mag32(bus.src_b, bus.op == MD_DIV);

    div_iter_r2 u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (bus.flush),
        .dividend  (div_a),
        .divisor   (div_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    // Sign fix: quotient negative when signs differ, remainder follows the dividend
    always_comb begin
        quo_fix = neg_quo ? (32'd0 - div_quo) : div_quo;
        rem_fix = neg_rem ? (32'd0 - div_rem) : div_rem;
    end

    // Sequencer FSM with registered busy/valid/result
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            busy_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            result_reg <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
        end else if (bus.flush) begin
            // Abort wins over everything, including completion; result is kept
            state     <= S_IDLE;
            cnt       <= '0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mul_a      <= bus.src_a;
                        mul_b      <= bus.src_b;
                        mul_signed <= (bus.op == MD_MULT);
                        neg_quo    <= (bus.op == MD_DIV) && (bus.src_a[31] ^ bus.src_b[31]);
                        neg_rem    <= (bus.op == MD_DIV) && bus.src_a[31];
                        cnt        <= '0;
                        busy_reg   <= 1'b1;
                        state      <= bus.op[1] ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    if (cnt == MUL_END) begin
                        state      <= S_DONE;
                        cnt        <= '0;
                        result_reg <= mul_out;
                        valid_reg  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if ((cnt == DIV_END) && div_done) begin
                        state      <= S_DONE;
                        cnt        <= '0;
                        result_reg <= {rem_fix, quo_fix};
                        valid_reg  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // Pipeline advances past this instruction on the first unheld edge
                    if (!bus.hold) begin
                        state     <= S_IDLE;
                        busy_reg  <= 1'b0;
                        valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall_req    = stall;
    assign bus.result_valid = valid_reg;
    assign bus.result       = result_reg;
    assign bus.busy         = busy_reg;

endmodule
`default_nettype wire
